round_key_ram_ctrl: RTL and testbench

Sequencer and port arbiter for the 16-byte round-key RAM: it accepts a 128-bit round key over a valid/ready handshake and writes it into the RAM one byte per cycle, and it shares the RAM's single address port with a byte-read requester from the round datapath. Byte 0 of the RAM holds key[127:120] and byte 15 holds key[7:0], consistent with the RAM's 128-bit readout concatenation. The block sits between the key-expansion unit (writer), the round engine (reader) and the RAM instance.

---
 rtl/round_key_ram_ctrl_pkg.sv | 21 ++
 rtl/round_key_ram_ctrl_if.sv | 58 +++++
 rtl/round_key_ram_ctrl.sv | 102 ++++++++++
 tb/tb_round_key_ram_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_key_ram_ctrl_pkg.sv
// Shared AES-128 round-key RAM constants and types.
// Widths are fixed by the 16-byte, 4-bit-address key RAM.
package round_key_ram_ctrl_pkg;

    localparam int AES_BYTES  = 16;
    localparam int AES_ADDR_W = 4;
    localparam int AES_KEY_W  = 128;

    typedef logic [AES_ADDR_W-1:0] addr_t;
    typedef logic [7:0]            byte_t;
    typedef logic [AES_KEY_W-1:0]  key_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam addr_t LAST_ADDR = addr_t'(AES_BYTES - 1);

endpackage

// File: rtl/round_key_ram_ctrl_if.sv
// Bundle of key-writer, byte-reader and RAM-side signals
// around the round-key RAM controller.
interface round_key_ram_ctrl_if;
    import round_key_ram_ctrl_pkg::*;

    key_t  key_in;
    logic  key_valid;
    logic  key_ready;

    logic  rd_req;
    addr_t rd_addr;
    logic  rd_gnt;
    byte_t rd_data;
    logic  rd_valid;

    logic  load_done;
    logic  busy;

    byte_t ram_in;
    addr_t ram_address;
    logic  ram_enable;
    byte_t ram_out;

    modport master (
        output key_in,
        output key_valid,
        output rd_req,
        output rd_addr,
        output ram_out,
        input  key_ready,
        input  rd_gnt,
        input  rd_data,
        input  rd_valid,
        input  load_done,
        input  busy,
        input  ram_in,
        input  ram_address,
        input  ram_enable
    );

    modport slave (
        input  key_in,
        input  key_valid,
        input  rd_req,
        input  rd_addr,
        input  ram_out,
        output key_ready,
        output rd_gnt,
        output rd_data,
        output rd_valid,
        output load_done,
        output busy,
        output ram_in,
        output ram_address,
        output ram_enable
    );

endinterface

// File: rtl/round_key_ram_ctrl.sv
// Round-key RAM sequencer: byte-serial key load with priority
// over single-byte reads on the shared RAM address port.
module round_key_ram_ctrl
    import round_key_ram_ctrl_pkg::*;
(
    input logic                clk,
    input logic                rst,
    round_key_ram_ctrl_if.slave bus
);

    state_e state_q, state_d;
    addr_t  cnt_q,   cnt_d;
    key_t   shift_q, shift_d;
    byte_t  rd_data_q, rd_data_d;
    logic   rd_valid_q, rd_valid_d;

    logic   key_ready;
    logic   rd_gnt;
    logic   load_done;
    logic   busy;
    byte_t  ram_in;
    addr_t  ram_address;
    logic   ram_enable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        key_ready   = 1'b0;
        rd_gnt      = 1'b0;
        load_done   = 1'b0;
        busy        = 1'b0;
        ram_in      = '0;
        ram_address = '0;
        ram_enable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Held low while in reset so no key is taken then.
                key_ready = rst;
                if (bus.key_valid) begin
                    shift_d = bus.key_in;
                    cnt_d   = '0;
                    state_d = LOAD;
                end else if (bus.rd_req && rst) begin
                    rd_gnt      = 1'b1;
                    ram_address = bus.rd_addr;
                    rd_data_d   = bus.ram_out;
                    rd_valid_d  = 1'b1;
                end
            end
            LOAD: begin
                busy        = 1'b1;
                ram_enable  = 1'b1;
                ram_address = cnt_q;
                ram_in      = shift_q[AES_KEY_W-1 -: 8];
                shift_d     = shift_q << 8;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_ready   = key_ready;
    assign bus.rd_gnt      = rd_gnt;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.load_done   = load_done;
    assign bus.busy        = busy;
    assign bus.ram_in      = ram_in;
    assign bus.ram_address = ram_address;
    assign bus.ram_enable  = ram_enable;

endmodule

// File: tb/tb_round_key_ram_ctrl.sv
// Bench for round_key_ram_ctrl: RAM model plus write/read
// scoreboards checked cycle by cycle.
module tb_round_key_ram_ctrl;
    import round_key_ram_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [7:0]   mem [16];
    wr_t          wq [$];
    logic [7:0]   rq [$];
    logic [127:0] cur_key;

    round_key_ram_ctrl_if bus ();

    round_key_ram_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.ram_enable) mem[bus.ram_address] <= bus.ram_in;
    end
    assign bus.ram_out = mem[bus.ram_address];

    function automatic logic [127:0] ram_image();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = mem[i];
        return r;
    endfunction

    function automatic logic [7:0] kbyte(input logic [127:0] k,
                                         input int a);
        return k[127-8*a -: 8];
    endfunction

    task automatic wait_hs(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.key_ready && bus.key_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!(bus.key_ready && bus.key_valid)) begin
            n_err++;
            $display("FAIL handshake: key_ready=%b never seen, want 1",
                     bus.key_ready);
            t = -1;
        end else begin
            t = cyc;
        end
    endtask

    // Called in the handshake cycle; walks T+1..T+18.
    task automatic load_observe(input logic [127:0] key,
                                input bit hold,
                                input logic [127:0] next_key,
                                output int t_done);
        wr_t e;
        for (int i = 0; i < 16; i++) begin
            e.addr = 4'(i);
            e.data = kbyte(key, i);
            wq.push_back(e);
        end
        t_done = -1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (hold) bus.key_in = next_key;
                else bus.key_valid = 1'b0;
            end
            @(negedge clk);
            if (k <= 16) begin
                n_cmp++;
                if ({bus.ram_enable, bus.busy, bus.load_done,
                     bus.rd_gnt} !== 4'b1100) begin
                    n_err++;
                    $display("FAIL load_ctl k=%0d: en/busy/done/gnt=%b want 1100",
                             k, {bus.ram_enable, bus.busy,
                                 bus.load_done, bus.rd_gnt});
                end
                n_cmp++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_scoreboard k=%0d: queue empty", k);
                end else begin
                    e = wq.pop_front();
                    if ({bus.ram_address, bus.ram_in} !== e) begin
                        n_err++;
                        $display("FAIL wr_byte k=%0d: addr/data=%h/%h want %h/%h",
                                 k, bus.ram_address, bus.ram_in,
                                 e.addr, e.data);
                    end
                end
            end else if (k == 17) begin
                t_done = cyc;
                n_cmp++;
                if ({bus.ram_enable, bus.busy, bus.load_done,
                     bus.rd_gnt, bus.key_ready} !== 5'b01100) begin
                    n_err++;
                    $display("FAIL done_ctl: en/busy/done/gnt/rdy=%b want 01100",
                             {bus.ram_enable, bus.busy, bus.load_done,
                              bus.rd_gnt, bus.key_ready});
                end
            end else begin
                n_cmp++;
                if ({bus.key_ready, bus.busy, bus.load_done,
                     bus.ram_enable} !== 4'b1000) begin
                    n_err++;
                    $display("FAIL idle_ctl: rdy/busy/done/en=%b want 1000",
                             {bus.key_ready, bus.busy, bus.load_done,
                              bus.ram_enable});
                end
            end
        end
        cur_key = key;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.key_ready, bus.busy, bus.load_done, bus.ram_enable,
             bus.rd_gnt, bus.rd_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl: rdy/busy/done/en/gnt/vld=%b want 000000",
                     {bus.key_ready, bus.busy, bus.load_done,
                      bus.ram_enable, bus.rd_gnt, bus.rd_valid});
        end
        n_cmp++;
        if ({bus.ram_address, bus.ram_in, bus.rd_data} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_bus: addr/in/rd_data=%h/%h/%h want 0/00/00",
                     bus.ram_address, bus.ram_in, bus.rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.key_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: key_ready=%b want 1",
                     bus.key_ready);
        end
    endtask

    task automatic test_load();
        logic [127:0] k;
        int t, td;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge clk); #1;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        wait_hs(t);
        load_observe(k, 1'b0, '0, td);
        n_cmp++;
        if (td - t != 17) begin
            n_err++;
            $display("FAIL load_done_lat: got %0d want 17", td - t);
        end
        n_cmp++;
        if (ram_image() !== k) begin
            n_err++;
            $display("FAIL readout: got %h want %h", ram_image(), k);
        end
    endtask

    task automatic test_read_single();
        @(posedge clk); #1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'h5;
        rq.push_back(kbyte(cur_key, 5));
        @(negedge clk);
        n_cmp++;
        if ({bus.rd_gnt, bus.ram_address} !== 5'b1_0101) begin
            n_err++;
            $display("FAIL rd_gnt: gnt/addr=%b/%h want 1/5",
                     bus.rd_gnt, bus.ram_address);
        end
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, rq.pop_front()}) begin
            n_err++;
            $display("FAIL rd_data: vld/data=%b/%h want 1/05",
                     bus.rd_valid, bus.rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_pulse: rd_valid=%b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_load_vs_read();
        logic [127:0] k;
        int t, td;
        k = 128'h8899aabbccddeeff0011223344556677;
        @(posedge clk); #1;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        bus.rd_req    = 1'b1;
        bus.rd_addr   = 4'h3;
        @(negedge clk);
        t = cyc;
        n_cmp++;
        if ({bus.rd_gnt, bus.key_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL prio: gnt/rdy=%b%b want 01",
                     bus.rd_gnt, bus.key_ready);
        end
        load_observe(k, 1'b0, '0, td);
        n_cmp++;
        if ({bus.rd_gnt, bus.ram_address} !== 5'b1_0011
            || cyc - t != 18) begin
            n_err++;
            $display("FAIL late_gnt: gnt/addr=%b/%h at +%0d want 1/3 at +18",
                     bus.rd_gnt, bus.ram_address, cyc - t);
        end
        rq.push_back(kbyte(k, 3));
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, rq.pop_front()}) begin
            n_err++;
            $display("FAIL late_data: vld/data=%b/%h want 1/bb",
                     bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_back_to_back_keys();
        logic [127:0] ka, kb;
        int t, td1, td2;
        ka = 128'h0123456789abcdeffedcba9876543210;
        kb = '1;
        @(posedge clk); #1;
        bus.key_in    = ka;
        bus.key_valid = 1'b1;
        wait_hs(t);
        load_observe(ka, 1'b1, kb, td1);
        n_cmp++;
        if (!(bus.key_ready && bus.key_valid)) begin
            n_err++;
            $display("FAIL second_hs: rdy/vld=%b%b want 11",
                     bus.key_ready, bus.key_valid);
        end
        load_observe(kb, 1'b0, '0, td2);
        n_cmp++;
        if (td2 - td1 != 18) begin
            n_err++;
            $display("FAIL done_spacing: got %0d want 18", td2 - td1);
        end
        n_cmp++;
        if (ram_image() !== kb) begin
            n_err++;
            $display("FAIL readout2: got %h want %h", ram_image(), kb);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [127:0] kc, kd;
        wr_t e;
        int t, td;
        bit bad;
        kc = 128'h00112233445566778899aabbccddeeff;
        kd = 128'hdeadbeefcafef00d0badc0de12345678;
        @(posedge clk); #1;
        bus.key_in    = kc;
        bus.key_valid = 1'b1;
        wait_hs(t);
        for (int i = 0; i < 16; i++) begin
            e.addr = 4'(i);
            e.data = kbyte(kc, i);
            wq.push_back(e);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.key_valid = 1'b0;
            if (k == 8) rst = 1'b0;
            @(negedge clk);
            e = wq.pop_front();
            n_cmp++;
            if ({bus.ram_enable, bus.busy, bus.ram_address,
                 bus.ram_in} !== {2'b11, e}) begin
                n_err++;
                $display("FAIL part_load k=%0d: en/busy/addr/in=%b%b/%h/%h want 11/%h/%h",
                         k, bus.ram_enable, bus.busy, bus.ram_address,
                         bus.ram_in, e.addr, e.data);
            end
        end
        wq.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.key_ready, bus.busy, bus.load_done, bus.ram_enable,
             bus.ram_address} !== 8'b1000_0000) begin
            n_err++;
            $display("FAIL abort: rdy/busy/done/en/addr=%b%b%b%b/%h want 1000/0",
                     bus.key_ready, bus.busy, bus.load_done,
                     bus.ram_enable, bus.ram_address);
        end
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.load_done !== 1'b0 || bus.ram_enable !== 1'b0)
                bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL stray_done: load_done/ram_enable seen 1, want 0");
        end
        @(posedge clk); #1;
        bus.key_in    = kd;
        bus.key_valid = 1'b1;
        wait_hs(t);
        load_observe(kd, 1'b0, '0, td);
        n_cmp++;
        if (ram_image() !== kd) begin
            n_err++;
            $display("FAIL readout3: got %h want %h", ram_image(), kd);
        end
    endtask

    task automatic test_read_sweep();
        logic [7:0] exp_b;
        for (int i = 0; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i < 16) begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = 4'(i);
                rq.push_back(kbyte(cur_key, i));
            end else begin
                bus.rd_req = 1'b0;
            end
            @(negedge clk);
            if (i < 16) begin
                n_cmp++;
                if ({bus.rd_gnt, bus.ram_address} !== {1'b1, 4'(i)}) begin
                    n_err++;
                    $display("FAIL sweep_gnt i=%0d: gnt/addr=%b/%h want 1/%h",
                             i, bus.rd_gnt, bus.ram_address, 4'(i));
                end
            end
            if (i > 0) begin
                exp_b = rq.pop_front();
                n_cmp++;
                if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp_b}) begin
                    n_err++;
                    $display("FAIL sweep_data i=%0d: vld/data=%b/%h want 1/%h",
                             i - 1, bus.rd_valid, bus.rd_data, exp_b);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc           = 0;
        n_cmp         = 0;
        n_err         = 0;
        cur_key       = '0;
        rst           = 1'b0;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        test_reset();
        test_load();
        test_read_single();
        test_load_vs_read();
        test_back_to_back_keys();
        test_reset_mid_load();
        test_read_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
